// File: rtl/icache_sa_refill.sv
// icache_sa_refill: set-associative instruction cache with multi-beat refill,
// round-robin replacement, flush and hit/miss counters.
module icache_sa_refill #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(SETS);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int NW = ADDR_W - OW - 2;
    localparam int TW = NW - IW;

    typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

    state_t                     state;
    logic [SETS-1:0][WAYS-1:0]  valid;
    logic [TW-1:0]              tag_mem  [SETS][WAYS];
    logic [31:0]                data_mem [SETS][WAYS][LINE_WORDS];
    logic [WW-1:0]              rr_ptr   [SETS];
    logic [NW-1:0]              line;
    logic [WW-1:0]              victim;
    logic [OW-1:0]              beat;
    logic                       flush_pend;

    logic [OW-1:0] offset;
    logic [IW-1:0] index;
    logic [TW-1:0] tag;
    logic [IW-1:0] fill_index;
    logic [TW-1:0] fill_tag;
    logic          hit;
    logic [WW-1:0] hit_way;
    logic          unused_pc_bits;

    assign offset         = pc[OW+1:2];
    assign index          = pc[OW+IW+1:OW+2];
    assign tag            = pc[ADDR_W-1:OW+IW+2];
    assign fill_index     = line[IW-1:0];
    assign fill_tag       = line[NW-1:IW];
    assign unused_pc_bits = ^pc[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[index][w] && tag_mem[index][w] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
        instr = hit ? data_mem[index][hit_way][offset] : 32'd0;
        stall = pc_valid && (state != IDLE || !hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
            flush_pend <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            beat       <= '0;
            line       <= '0;
            victim     <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (pc_valid && hit) begin
                        hit_count <= hit_count + 32'd1;
                    end else if (pc_valid) begin
                        line       <= pc[ADDR_W-1:OW+2];
                        victim     <= rr_ptr[index];
                        beat       <= '0;
                        miss_count <= miss_count + 32'd1;
                        mem_req    <= 1'b1;
                        mem_addr   <= {pc[ADDR_W-1:OW+2], {(OW+2){1'b0}}};
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_ack) begin
                        beat     <= beat + 1'b1;
                        mem_addr <= {line, OW'(beat + 1'b1), 2'b00};
                        if (beat == OW'(LINE_WORDS - 1)) begin
                            mem_req <= 1'b0;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A flush seen at any point of the refill drops everything, including this line
                    if (flush || flush_pend) valid <= '0;
                    else valid[fill_index][victim] <= 1'b1;
                    rr_ptr[fill_index] <= (WAYS == 1) ? '0 : rr_ptr[fill_index] + 1'b1;
                    flush_pend         <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ack) data_mem[fill_index][victim][beat] <= mem_rdata;
        if (state == DONE) tag_mem[fill_index][victim] <= fill_tag;
    end
endmodule

// File: doc/icache_sa_refill.md
Name: icache_sa_refill

Overview:
- Parametrised set-associative instruction cache between the fetch stage (pc in, instr/stall out) and a word-wide instruction memory port.
- Generalises the direct fetch/stall cache to configurable sets, ways and line length.
- Adds a multi-beat refill handshake, round-robin replacement, a flush input and hit/miss counters.

Parameters:
ADDR_W, 32, byte address width of pc and mem_addr
SETS, 16, number of sets (power of 2, >=2)
WAYS, 2, associativity (power of 2, 1..8)
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
pc  in  ADDR_W  fetch byte address (bits [1:0] ignored)
pc_valid  in  1  fetch request this cycle
flush  in  1  invalidate entire cache
instr  out  32  fetched instruction, valid when pc_valid && !stall
stall  out  1  fetch must hold pc and retry
mem_req  out  1  refill beat request
mem_addr  out  ADDR_W  word-aligned refill beat address
mem_ack  in  1  beat accepted; mem_rdata valid this cycle
mem_rdata  in  32  refill data
hit_count  out  32  lookups that hit (wraps)
miss_count  out  32  misses started (wraps)

Behaviour:
- Address split: offset = pc[log2(LINE_WORDS)+1:2]; index = next log2(SETS) bits; tag = remaining upper bits.
- Storage: valid/tag/data per way per set; rr_ptr[log2(WAYS)] per set.
- Lookup is combinational in IDLE.
  - hit = any way with valid && tag match at index.
  - instr = matching way's word at offset; otherwise instr = 0.
  - stall = pc_valid && (state != IDLE || !hit).
  - Zero-latency hit: same-cycle instr.
- FSM:
  - IDLE: on pc_valid && !hit && !flush, capture line base (pc with offset zeroed) and victim way = rr_ptr[index]. Set beat = 0, increment miss_count, go to REFILL.
  - REFILL: mem_req = 1; mem_addr = line_base + 4*beat, held stable until mem_ack.
    - On mem_ack: write mem_rdata into victim way at word beat and increment beat.
    - mem_ack on the last beat goes to DONE.
    - mem_ack may be high in the first REFILL cycle (zero-wait).
  - DONE (1 cycle): mem_req = 0. Write tag and set valid for the victim, unless a flush is pending. rr_ptr[index] += 1 (wraps at WAYS). Go to IDLE.
  - The next IDLE cycle re-looks up pc and hits.
- Miss penalty with zero-wait memory: LINE_WORDS + 2 cycles from miss detection to the hit cycle.
- hit_count increments in any IDLE cycle with pc_valid && hit && !flush.
- The requester holds pc stable while stall = 1. Refill uses only the captured line base, so a changed pc still completes the original refill correctly.
- flush in IDLE: all valid bits clear at the next edge. rr_ptrs and counters are unchanged. No refill starts that cycle.
- flush during REFILL/DONE: latched into flush_pend. The refill runs to completion (no beat abandoned). At DONE all valid bits clear and the filled line is not validated. flush_pend clears.
- A victim way that is already valid is overwritten with no writeback (read-only cache).
- Reset (async, any state including mid-refill):
  - state IDLE; all valid = 0; rr_ptrs = 0; flush_pend = 0.
  - mem_req = 0; mem_addr = 0; beat = 0.
  - hit_count = miss_count = 0.
  - instr = 0 and stall = pc_valid.
  - Tag/data contents need no reset.
- Counters wrap 0xFFFFFFFF -> 0.

Test Plan:
- Cold miss (SETS=16, WAYS=2, LINE_WORDS=4), pc=0x100, mem_ack 2 cycles after each mem_req, rdata=addr^0xA5A5A5A5 -> mem_addr sequence 0x100,0x104,0x108,0x10C. stall high throughout. Next IDLE cycle gives instr=0x100^0xA5A5A5A5 with stall=0. miss_count=1.
- After that fill, pc=0x108 then 0x10C back-to-back -> stall=0 both cycles, instr=0x108^0xA5A5A5A5 and 0x10C^0xA5A5A5A5 the same cycle, hit_count+=2, no mem_req.
- Conflict: fetch 0x100, 0x500, 0x900 (same index 0), then 0x100 -> 0x900 evicts way0 (the 0x100 line). 0x100 misses again, miss_count=4, and its refill replaces way1 (the 0x500 line). 0x900 still hits.
- Zero-wait memory (mem_ack tied high) on a miss -> exactly 4 mem_req cycles, stall deasserts LINE_WORDS+2 cycles after the miss.
- flush pulsed during beat 2 of a refill -> all 4 beats complete, then pc re-misses. mem_addr restarts at line base. Previously valid lines also miss.
- rst asserted mid-refill (beat 1) -> mem_req=0 asynchronously, counters=0. The same pc re-misses after release, with beat 0 at the line base.
